// File: rtl/instructie_ophaler.sv
// Instruction fetch unit: drives program-memory reads from the PC, buffers fetched
// words in a small FIFO and hands them to the decoder. A jump flushes the buffer,
// retargets the PC and discards any read that is still in flight.
module instructie_ophaler #(
  parameter int unsigned ADRES_BREEDTE = 8,
  parameter int unsigned INSTR_BREEDTE = 9,
  parameter int unsigned FIFO_DIEPTE   = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic [ADRES_BREEDTE-1:0] mem_adres,
  output logic                     mem_lees,
  input  logic                     mem_klaar,
  input  logic [INSTR_BREEDTE-1:0] mem_data,
  input  logic                     sprong,
  input  logic [ADRES_BREEDTE-1:0] sprong_adres,
  output logic [INSTR_BREEDTE-1:0] instructie,
  output logic                     instructie_geldig,
  input  logic                     instructie_neem
);

  localparam int unsigned PW = (FIFO_DIEPTE > 1) ? $clog2(FIFO_DIEPTE) : 1;
  localparam int unsigned CW = $clog2(FIFO_DIEPTE + 1);
  localparam logic [CW-1:0] DiepteC = CW'(FIFO_DIEPTE);
  localparam logic [PW-1:0] PtrMax  = PW'(FIFO_DIEPTE - 1);

  typedef enum logic [1:0] {
    StWacht,
    StLees,
    StVerwerp
  } toestand_e;

  // State and registered outputs
  toestand_e                r_toestand;
  logic [ADRES_BREEDTE-1:0] r_pc;
  logic [ADRES_BREEDTE-1:0] r_mem_adres;
  logic                     r_mem_lees;

  // Prefetch buffer
  logic [INSTR_BREEDTE-1:0] r_buf [FIFO_DIEPTE];
  logic [PW-1:0]            r_rd;
  logic [PW-1:0]            r_wr;
  logic [CW-1:0]            r_count;
  logic [INSTR_BREEDTE-1:0] r_instructie;
  logic                     r_geldig;

  // Next-state wires
  logic                     w_voltooi;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_leeg_na_pop;
  logic                     w_vrij;
  logic [CW-1:0]            w_count_d;
  logic [PW-1:0]            w_rd_d;
  logic [PW-1:0]            w_wr_d;
  logic [INSTR_BREEDTE-1:0] w_kop_d;
  toestand_e                w_toestand_d;
  logic [ADRES_BREEDTE-1:0] w_pc_d;
  logic [ADRES_BREEDTE-1:0] w_adres_d;

  function automatic logic [PW-1:0] volgende(input logic [PW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  assign mem_adres         = r_mem_adres;
  assign mem_lees          = r_mem_lees;
  assign instructie        = r_instructie;
  assign instructie_geldig = r_geldig;

  // FIFO bookkeeping: a jump wins over both push and pop
  always_comb begin
    w_voltooi = r_mem_lees & mem_klaar;
    // Only a completion in StLees carries a word we want; StVerwerp completions are dropped
    w_push    = (r_toestand == StLees) & w_voltooi & ~sprong;
    w_pop     = instructie_neem & r_geldig & ~sprong;

    w_count_d = r_count;
    w_rd_d    = r_rd;
    w_wr_d    = r_wr;
    if (sprong) begin
      w_count_d = '0;
      w_rd_d    = '0;
      w_wr_d    = '0;
    end else begin
      if (w_push && !w_pop) begin
        w_count_d = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        w_count_d = r_count - CW'(1);
      end
      if (w_pop) begin
        w_rd_d = volgende(r_rd);
      end
      if (w_push) begin
        w_wr_d = volgende(r_wr);
      end
    end

    // Head register: the incoming word becomes head only if nothing older survives the pop
    w_leeg_na_pop = w_pop ? (r_count == CW'(1)) : (r_count == '0);
    w_kop_d       = r_instructie;
    if (!sprong && (w_count_d != '0)) begin
      if (w_push && w_leeg_na_pop) begin
        w_kop_d = mem_data;
      end else begin
        w_kop_d = r_buf[w_rd_d];
      end
    end
  end

  // Fetch FSM next state, PC and memory request
  always_comb begin
    w_vrij       = (w_count_d < DiepteC);
    w_toestand_d = r_toestand;
    w_pc_d       = r_pc;
    if (sprong) begin
      w_pc_d = sprong_adres;
      unique case (r_toestand)
        StLees, StVerwerp: w_toestand_d = w_voltooi ? StLees : StVerwerp;
        default:           w_toestand_d = StLees;
      endcase
    end else begin
      unique case (r_toestand)
        StWacht: begin
          if (w_vrij) begin
            w_toestand_d = StLees;
          end
        end
        StLees: begin
          if (w_voltooi) begin
            w_pc_d       = r_pc + 1'b1;
            w_toestand_d = w_vrij ? StLees : StWacht;
          end
        end
        StVerwerp: begin
          if (w_voltooi) begin
            w_toestand_d = w_vrij ? StLees : StWacht;
          end
        end
        default: w_toestand_d = StWacht;
      endcase
    end
    // While discarding, keep presenting the aborted address until memory answers
    w_adres_d = (w_toestand_d == StVerwerp) ? r_mem_adres : w_pc_d;
  end

  // FSM register with registered memory-side outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_toestand  <= StWacht;
      r_pc        <= '0;
      r_mem_adres <= '0;
      r_mem_lees  <= 1'b0;
    end else begin
      r_toestand  <= w_toestand_d;
      r_pc        <= w_pc_d;
      r_mem_adres <= w_adres_d;
      r_mem_lees  <= (w_toestand_d != StWacht);
    end
  end

  // FIFO pointers, occupancy and decoder-side outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_instructie <= '0;
      r_geldig     <= 1'b0;
    end else begin
      r_rd         <= w_rd_d;
      r_wr         <= w_wr_d;
      r_count      <= w_count_d;
      r_instructie <= w_kop_d;
      r_geldig     <= (w_count_d != '0);
    end
  end

  // Buffer storage; contents are only meaningful under r_count
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_buf[r_wr] <= mem_data;
    end
  end

endmodule

// File: tb/tb_instructie_ophaler.sv
// Randomised scoreboard bench for the instruction fetch unit.
module tb_instructie_ophaler;

  localparam int unsigned AB = 8;
  localparam int unsigned IB = 9;
  localparam int unsigned D  = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AB-1:0] mem_adres;
  logic          mem_lees;
  logic          mem_klaar = 1'b0;
  logic [IB-1:0] mem_data;
  logic          sprong = 1'b0;
  logic [AB-1:0] sprong_adres = '0;
  logic [IB-1:0] instructie;
  logic          instructie_geldig;
  logic          instructie_neem = 1'b0;
  bit            r_mode = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  logic [IB-1:0] exp_q[$];
  logic [IB-1:0] deliv_log[$];
  logic [AB-1:0] m_pc = '0;
  logic [AB-1:0] m_aborted = '0;
  bit            m_discard = 1'b0;
  bit            m_started = 1'b0;

  instructie_ophaler #(
    .ADRES_BREEDTE(AB),
    .INSTR_BREEDTE(IB),
    .FIFO_DIEPTE  (D)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .mem_adres        (mem_adres),
    .mem_lees         (mem_lees),
    .mem_klaar        (mem_klaar),
    .mem_data         (mem_data),
    .sprong           (sprong),
    .sprong_adres     (sprong_adres),
    .instructie       (instructie),
    .instructie_geldig(instructie_geldig),
    .instructie_neem  (instructie_neem)
  );

  always #5 clock = ~clock;

  // Program memory contents as a function of address
  function automatic logic [IB-1:0] dat(input logic [AB-1:0] a, input bit m);
    logic [IB-1:0] r;
    if (m) r = {a[2] ^ a[7], a ^ 8'h5A};
    else   r = 9'h100 + {1'b0, a};
    return r;
  endfunction

  assign mem_data = dat(mem_adres, r_mode);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [IB-1:0] log_at(input int i);
    return (i < deliv_log.size()) ? deliv_log[i] : 'x;
  endfunction

  // Monitor: invariants against the model, plus pop-and-compare on every accepted word
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("reset_lees", 32'(mem_lees), 32'(0));
      chk("reset_geldig", 32'(instructie_geldig), 32'(0));
      chk("reset_adres", 32'(mem_adres), 32'(0));
      chk("reset_instructie", 32'(instructie), 32'(0));
    end else begin
      chk("geldig", 32'(instructie_geldig), 32'(exp_q.size() != 0));
      chk("lees", 32'(mem_lees), 32'(m_started && (m_discard || exp_q.size() < D)));
      if (mem_lees) chk("adres", 32'(mem_adres), 32'(m_discard ? m_aborted : m_pc));
      if (instructie_geldig && instructie_neem && !sprong) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL data: got %0h, expected no word at %0t", instructie, $time);
        end else begin
          chk("data", 32'(instructie), 32'(exp_q.pop_front()));
          deliv_log.push_back(instructie);
          n_deliv++;
        end
      end
    end
  end

  // Reference model: predicts the effect of the coming edge from the settled inputs
  always @(negedge clock) begin
    #2;
    if (!reset_n) begin
      exp_q.delete();
      m_pc      = '0;
      m_discard = 1'b0;
      m_started = 1'b0;
    end else begin
      bit compl;
      compl = mem_lees && mem_klaar;
      if (sprong) begin
        exp_q.delete();
        if (compl) begin
          m_discard = 1'b0;
        end else if (mem_lees && !m_discard) begin
          m_aborted = m_pc;
          m_discard = 1'b1;
        end
        m_pc = sprong_adres;
      end else if (compl) begin
        if (m_discard) begin
          m_discard = 1'b0;
        end else begin
          exp_q.push_back(dat(m_pc, r_mode));
          m_pc = m_pc + 1'b1;
        end
      end
      m_started = 1'b1;
    end
  end

  task automatic cyc(input bit k, input bit n, input bit s, input logic [AB-1:0] t,
                     input int cnt);
    for (int i = 0; i < cnt; i++) begin
      mem_klaar       = k;
      instructie_neem = n;
      sprong          = s;
      sprong_adres    = t;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int d0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Streaming fetch
    d0 = n_deliv;
    cyc(1, 1, 0, 8'h00, 20);
    chk("stream_count", 32'(n_deliv - d0), 32'(18));
    chk("stream_w0", 32'(log_at(d0)), 32'(9'h100));
    chk("stream_w1", 32'(log_at(d0 + 1)), 32'(9'h101));

    // Backpressure
    cyc(1, 0, 0, 8'h00, 10);
    chk("bp_fill", 32'(exp_q.size()), 32'(D));
    chk("bp_lees", 32'(mem_lees), 32'(0));
    d0 = n_deliv;
    cyc(1, 1, 0, 8'h00, 10);
    chk("bp_first", 32'(log_at(d0)), 32'(dat(8'd18, 1'b0)));
    chk("bp_second", 32'(log_at(d0 + 1)), 32'(dat(8'd19, 1'b0)));

    // Slow memory
    for (int i = 0; i < 30; i++) cyc((i % 3) == 2, 1'($urandom_range(0, 1)), 0, 8'h00, 1);

    // Jump while a read is in flight
    cyc(1, 1, 1, 8'h05, 1);
    cyc(0, 1, 0, 8'h00, 1);
    chk("jf_wait5", 32'(mem_adres), 32'(8'h05));
    cyc(0, 1, 1, 8'h40, 1);
    chk("jf_hold", 32'(mem_adres), 32'(8'h05));
    cyc(0, 1, 0, 8'h00, 1);
    cyc(1, 1, 0, 8'h00, 1);
    chk("jf_next", 32'(mem_adres), 32'(8'h40));
    d0 = n_deliv;
    cyc(1, 1, 0, 8'h00, 4);
    chk("jf_first", 32'(log_at(d0)), 32'(dat(8'h40, 1'b0)));

    // Jump, completion and accept on the same edge
    cyc(1, 1, 0, 8'h00, 4);
    chk("sim_pre_geldig", 32'(instructie_geldig), 32'(1));
    cyc(1, 1, 1, 8'h80, 1);
    chk("sim_geldig", 32'(instructie_geldig), 32'(0));
    chk("sim_lees", 32'(mem_lees), 32'(1));
    chk("sim_adres", 32'(mem_adres), 32'(8'h80));
    d0 = n_deliv;
    cyc(1, 1, 0, 8'h00, 3);
    chk("sim_first", 32'(log_at(d0)), 32'(dat(8'h80, 1'b0)));

    // PC wrap-around
    cyc(1, 1, 1, 8'hFF, 1);
    chk("wrap_ff", 32'(mem_adres), 32'(8'hFF));
    d0 = n_deliv;
    cyc(1, 1, 0, 8'h00, 1);
    chk("wrap_00", 32'(mem_adres), 32'(8'h00));
    cyc(1, 1, 0, 8'h00, 3);
    chk("wrap_w0", 32'(log_at(d0)), 32'(dat(8'hFF, 1'b0)));
    chk("wrap_w1", 32'(log_at(d0 + 1)), 32'(dat(8'h00, 1'b0)));

    // Random traffic with random jumps
    r_mode = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          8'($urandom), 1);
    end
    chk("rand_progress", 32'(n_deliv - d0 > 50), 32'(1));

    // Reset in the middle of a read with a word buffered
    r_mode = 1'b0;
    cyc(1, 0, 1, 8'h33, 1);
    cyc(1, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("mid_pre_lees", 32'(mem_lees), 32'(1));
    chk("mid_pre_geldig", 32'(instructie_geldig), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_lees", 32'(mem_lees), 32'(0));
    chk("mid_rst_geldig", 32'(instructie_geldig), 32'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;
    cyc(1, 1, 0, 8'h00, 1);
    chk("mid_restart_lees", 32'(mem_lees), 32'(1));
    chk("mid_restart_adres", 32'(mem_adres), 32'(0));
    d0 = n_deliv;
    cyc(1, 1, 0, 8'h00, 4);
    chk("mid_restart_w0", 32'(log_at(d0)), 32'(dat(8'h00, 1'b0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
